// File: rtl/in_spike_pkg.sv
// Shared definitions for the ping-pong input spike buffer.
// Provides the spike popcount helper, the axon address-width check and the
// learn-history bit-order constant used by the buffer and its banks.
package in_spike_pkg;

    // Widest spike vector the popcount helper accepts.
    localparam int MAX_AXONS = 1024;

    // Learn-history bit that holds the most recently saved timestep.
    localparam int LRN_NEWEST_BIT = 0;

    // Number of set bits in a spike vector, zero-extended to MAX_AXONS.
    function automatic int popcount(input logic [MAX_AXONS-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_AXONS; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

    // True when an address of width aw can reach every one of num_axons axons.
    function automatic bit axon_width_ok(input int num_axons, input int aw);
        return (longint'(1) << aw) >= longint'(num_axons);
    endfunction

endpackage

// File: rtl/in_spike_buf_pp_bank.sv
// spike_bank: one NUM_AXONS-bit spike register with set-by-address, OR-load,
// clear and a 1-cycle registered single-bit read.
// Ports: set_en/set_addr (set one bit), ld_en/ld_vec (OR a vector in),
// clr (clear; same-edge set/load still land), rd_en/rd_addr -> rd_dat (held
// when rd_en low, 0 for out-of-range addresses), vec (current contents).
module spike_bank
    import in_spike_pkg::*;
#(
    parameter int NUM_AXONS          = 256,
    parameter int AXON_CNT_BIT_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          set_en,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] set_addr,
    input  logic                          ld_en,
    input  logic [NUM_AXONS-1:0]          ld_vec,
    input  logic                          clr,
    input  logic                          rd_en,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] rd_addr,
    output logic                          rd_dat,
    output logic [NUM_AXONS-1:0]          vec
);

    logic [NUM_AXONS-1:0] set_mask;
    logic [NUM_AXONS-1:0] vec_nxt;
    logic                 rd_bit;

    // Address decode by comparison: addresses >= NUM_AXONS match nothing,
    // so out-of-range sets are dropped and out-of-range reads return 0.
    always_comb begin
        set_mask = '0;
        rd_bit   = 1'b0;
        for (int i = 0; i < NUM_AXONS; i++) begin
            if (set_en && (set_addr == AXON_CNT_BIT_WIDTH'(i))) begin
                set_mask[i] = 1'b1;
            end
            if (rd_addr == AXON_CNT_BIT_WIDTH'(i)) begin
                rd_bit = vec[i];
            end
        end
    end

    // Clear only drops old contents; writes in the same cycle survive.
    always_comb begin
        vec_nxt = (clr ? '0 : vec) | set_mask | (ld_en ? ld_vec : '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vec    <= '0;
            rd_dat <= 1'b0;
        end else begin
            vec <= vec_nxt;
            if (rd_en) begin
                rd_dat <= rd_bit;
            end
        end
    end

endmodule

// File: rtl/in_spike_buf_pp.sv
// in_spike_buf_pp: ping-pong input spike buffer with per-axon learn history.
// Ports: start_i swaps banks; spk_vld_i/spk_axon_i/spk_rdy_o addressed events;
// bulk_ld_i/spike_in vector OR-load; rdEn_RclInSpike_i/RclAxonAddr_i ->
// Rcl_InSpike_o (1-cycle); saveRclSpikes_i shifts active bank into history;
// rdEn_LrnInSpike_i/LrnAxonAddr_i -> Lrn_InSpike_o (1-cycle, bit0 newest);
// rcl_spk_cnt_o popcount of bank made active at last start; err_o sticky range error.
module in_spike_buf_pp
    import in_spike_pkg::*;
#(
    parameter int NUM_AXONS          = 256,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int LRN_DEPTH          = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    input  logic                          spk_vld_i,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] spk_axon_i,
    output logic                          spk_rdy_o,
    input  logic                          bulk_ld_i,
    input  logic [NUM_AXONS-1:0]          spike_in,
    input  logic                          rdEn_RclInSpike_i,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] RclAxonAddr_i,
    output logic                          Rcl_InSpike_o,
    input  logic                          saveRclSpikes_i,
    input  logic                          rdEn_LrnInSpike_i,
    input  logic [AXON_CNT_BIT_WIDTH-1:0] LrnAxonAddr_i,
    output logic [LRN_DEPTH-1:0]          Lrn_InSpike_o,
    output logic [AXON_CNT_BIT_WIDTH:0]   rcl_spk_cnt_o,
    output logic                          err_o
);

    localparam int AW = AXON_CNT_BIT_WIDTH;
    localparam logic [AW:0] NUM_AXONS_W = (AW+1)'(NUM_AXONS);

    generate
        if (!axon_width_ok(NUM_AXONS, AW) || (NUM_AXONS > MAX_AXONS) || (LRN_DEPTH < 1)) begin : g_bad_cfg
            $error("in_spike_buf_pp: unsupported NUM_AXONS/AXON_CNT_BIT_WIDTH/LRN_DEPTH");
        end
    endgenerate

    logic                 sel;       // active bank index; fill bank is !sel
    logic                 rd_sel_q;  // bank that produced the held recall read
    logic                 accept;
    logic                 in_range;
    logic                 wr_bank;
    logic [NUM_AXONS-1:0] bank_vec [2];
    logic                 bank_rd  [2];
    logic [NUM_AXONS-1:0] active_vec;
    logic [NUM_AXONS-1:0] fill_vec;
    logic [LRN_DEPTH-1:0] hist [NUM_AXONS];
    logic [LRN_DEPTH-1:0] lrn_rd;

    assign accept   = spk_vld_i & spk_rdy_o;
    assign in_range = ({1'b0, spk_axon_i} < NUM_AXONS_W);

    // In a start_i cycle writes go to the post-swap fill bank, which is the
    // bank being cleared; its clear yields to them inside spike_bank.
    assign wr_bank = start_i ? sel : ~sel;

    assign active_vec = sel ? bank_vec[1] : bank_vec[0];
    assign fill_vec   = sel ? bank_vec[0] : bank_vec[1];

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            spike_bank #(
                .NUM_AXONS         (NUM_AXONS),
                .AXON_CNT_BIT_WIDTH(AW)
            ) u_bank (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .set_en  (accept & in_range & (wr_bank == 1'(b))),
                .set_addr(spk_axon_i),
                .ld_en   (bulk_ld_i & (wr_bank == 1'(b))),
                .ld_vec  (spike_in),
                .clr     (start_i & (sel == 1'(b))),
                .rd_en   (rdEn_RclInSpike_i),
                .rd_addr (RclAxonAddr_i),
                .rd_dat  (bank_rd[b]),
                .vec     (bank_vec[b])
            );
        end
    endgenerate

    // Both banks read every enabled cycle; remember which one was active.
    assign Rcl_InSpike_o = rd_sel_q ? bank_rd[1] : bank_rd[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel           <= 1'b0;
            rd_sel_q      <= 1'b0;
            spk_rdy_o     <= 1'b0;
            err_o         <= 1'b0;
            rcl_spk_cnt_o <= '0;
        end else begin
            spk_rdy_o <= 1'b1;
            if (accept && !in_range) begin
                err_o <= 1'b1;
            end
            if (rdEn_RclInSpike_i) begin
                rd_sel_q <= sel;
            end
            if (start_i) begin
                sel           <= ~sel;
                rcl_spk_cnt_o <= (AW+1)'(popcount(MAX_AXONS'(fill_vec)));
            end
        end
    end

    // Learn read looks up pre-shift history (read-before-write on save).
    always_comb begin
        lrn_rd = '0;
        for (int i = 0; i < NUM_AXONS; i++) begin
            if (LrnAxonAddr_i == AW'(i)) begin
                lrn_rd = hist[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            Lrn_InSpike_o <= '0;
            for (int i = 0; i < NUM_AXONS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (rdEn_LrnInSpike_i) begin
                Lrn_InSpike_o <= lrn_rd;
            end
            if (saveRclSpikes_i) begin
                // Older entries move toward the MSB; the oldest falls off.
                for (int i = 0; i < NUM_AXONS; i++) begin
                    hist[i] <= (hist[i] << 1) | (LRN_DEPTH'(active_vec[i]) << LRN_NEWEST_BIT);
                end
            end
        end
    end

endmodule

// File: tb/tb_in_spike_buf_pp.sv
module tb_in_spike_buf_pp;

    localparam int N  = 256;
    localparam int AW = 9;
    localparam int LD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          spk_vld;
    logic [AW-1:0] spk_axon;
    logic          spk_rdy;
    logic          bulk_ld;
    logic [N-1:0]  spike_in;
    logic          rcl_en;
    logic [AW-1:0] rcl_addr;
    logic          rcl_out;
    logic          save;
    logic          lrn_en;
    logic [AW-1:0] lrn_addr;
    logic [LD-1:0] lrn_out;
    logic [AW:0]   cnt;
    logic          err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    in_spike_buf_pp #(
        .NUM_AXONS         (N),
        .AXON_CNT_BIT_WIDTH(AW),
        .LRN_DEPTH         (LD)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .start_i          (start),
        .spk_vld_i        (spk_vld),
        .spk_axon_i       (spk_axon),
        .spk_rdy_o        (spk_rdy),
        .bulk_ld_i        (bulk_ld),
        .spike_in         (spike_in),
        .rdEn_RclInSpike_i(rcl_en),
        .RclAxonAddr_i    (rcl_addr),
        .Rcl_InSpike_o    (rcl_out),
        .saveRclSpikes_i  (save),
        .rdEn_LrnInSpike_i(lrn_en),
        .LrnAxonAddr_i    (lrn_addr),
        .Lrn_InSpike_o    (lrn_out),
        .rcl_spk_cnt_o    (cnt),
        .err_o            (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timestep view: "active" is what the crossbar sees, "fill" is what is
    // being collected for the next timestep; history is a per-axon shift list.
    logic [N-1:0]  m_act, m_fil;
    logic [LD-1:0] m_hist [N];
    logic          m_rcl, m_rdy, m_err;
    logic [LD-1:0] m_lrn;
    logic [AW:0]   m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = '0; m_fil = '0;
            for (int a = 0; a < N; a++) m_hist[a] = '0;
            m_rcl = 0; m_rdy = 0; m_err = 0; m_lrn = '0; m_cnt = '0;
        end else begin
            if (rcl_en) m_rcl = (int'(rcl_addr) < N) ? m_act[rcl_addr] : 1'b0;
            if (lrn_en) m_lrn = (int'(lrn_addr) < N) ? m_hist[lrn_addr] : '0;
            if (save)
                for (int a = 0; a < N; a++) m_hist[a] = {m_hist[a][LD-2:0], m_act[a]};
            if (start) begin
                m_cnt = (AW+1)'($countones(m_fil));
                m_act = m_fil;
                m_fil = '0;
            end
            if (spk_vld && m_rdy) begin
                if (int'(spk_axon) < N) m_fil[spk_axon] = 1'b1;
                else m_err = 1'b1;
            end
            if (bulk_ld) m_fil = m_fil | spike_in;
            m_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("cyc_rcl", 32'(rcl_out), 32'(m_rcl));
        check("cyc_lrn", 32'(lrn_out), 32'(m_lrn));
        check("cyc_cnt", 32'(cnt), 32'(m_cnt));
        check("cyc_err", 32'(err), 32'(m_err));
        check("cyc_rdy", 32'(spk_rdy), 32'(m_rdy));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        start = 0; spk_vld = 0; bulk_ld = 0; rcl_en = 0; save = 0; lrn_en = 0;
        spike_in = '0;
    endtask

    task automatic ev(input int a);
        spk_vld = 1; spk_axon = AW'(a);
        cyc();
    endtask

    task automatic do_start();
        start = 1;
        cyc();
    endtask

    task automatic rcl_expect(input string name, input int a, input logic exp);
        rcl_en = 1; rcl_addr = AW'(a);
        cyc();
        check(name, 32'(rcl_out), 32'(exp));
    endtask

    task automatic lrn_expect(input string name, input int a, input logic [LD-1:0] exp);
        lrn_en = 1; lrn_addr = AW'(a);
        cyc();
        check(name, 32'(lrn_out), 32'(exp));
    endtask

    initial begin
        rst_n = 0; start = 0; spk_vld = 0; spk_axon = '0; bulk_ld = 0; spike_in = '0;
        rcl_en = 0; rcl_addr = '0; save = 0; lrn_en = 0; lrn_addr = '0;
        #2;
        check("reset_rdy", 32'(spk_rdy), 0);
        check("reset_cnt", 32'(cnt), 0);
        check("reset_err", 32'(err), 0);
        cyc(); cyc();
        rst_n = 1;
        check("rdy_before_edge", 32'(spk_rdy), 0);
        cyc();
        check("rdy_after_edge", 32'(spk_rdy), 1);

        // 1: events 3,7,7,200
        ev(3); ev(7); ev(7); ev(200);
        do_start();
        check("t1_cnt", 32'(cnt), 3);
        rcl_expect("t1_rd3", 3, 1'b1);
        rcl_expect("t1_rd7", 7, 1'b1);
        rcl_expect("t1_rd200", 200, 1'b1);
        rcl_addr = AW'(4);
        cyc();
        check("t1_hold", 32'(rcl_out), 1);
        rcl_expect("t1_rd4", 4, 1'b0);

        // 2: event in the start cycle lands in the new fill bank
        spk_vld = 1; spk_axon = AW'(5); start = 1;
        cyc();
        check("t2_cnt0", 32'(cnt), 0);
        do_start();
        check("t2_cnt1", 32'(cnt), 1);
        rcl_expect("t2_rd5", 5, 1'b1);
        rcl_expect("t2_rd3", 3, 1'b0);
        rcl_expect("t2_rd200", 200, 1'b0);

        // 3: bulk load plus same-cycle event
        bulk_ld = 1; spike_in = N'(8'hF0); spk_vld = 1; spk_axon = AW'(0);
        cyc();
        do_start();
        check("t3_cnt", 32'(cnt), 5);
        rcl_expect("t3_rd0", 0, 1'b1);
        rcl_expect("t3_rd4", 4, 1'b1);
        rcl_expect("t3_rd7", 7, 1'b1);
        rcl_expect("t3_rd3", 3, 1'b0);
        rcl_expect("t3_rd8", 8, 1'b0);

        // 4: learn history
        ev(2);
        do_start();
        save = 1;
        cyc();
        ev(2); ev(9);
        do_start();
        save = 1;
        cyc();
        lrn_expect("t4_h2", 2, 4'b0011);
        lrn_expect("t4_h9", 9, 4'b0001);
        do_start();                              // active now empty
        save = 1; lrn_en = 1; lrn_addr = AW'(2);
        cyc();
        check("t4_rbw", 32'(lrn_out), 32'b0011);
        save = 1;
        cyc();
        lrn_expect("t4_h2_old", 2, 4'b1100);
        lrn_expect("t4_h9_old", 9, 4'b0100);
        // save together with start records the pre-swap active bank
        ev(11);
        do_start();
        ev(12);
        start = 1; save = 1;
        cyc();
        lrn_expect("t4_h11", 11, 4'b0001);
        lrn_expect("t4_h12", 12, 4'b0000);

        // 5: out-of-range event
        do_start();                              // flush 12 to active, fill empty
        ev(300);
        check("t5_err", 32'(err), 1);
        do_start();
        check("t5_cnt", 32'(cnt), 0);
        check("t5_err_sticky", 32'(err), 1);
        rcl_expect("t5_rd44", 44, 1'b0);
        rcl_expect("t5_rd300", 300, 1'b0);

        // 6: reset mid-fill
        for (int a = 10; a < 20; a++) ev(a);
        do_start();
        for (int a = 20; a < 30; a++) ev(a);
        check("t6_cnt_pre", 32'(cnt), 10);
        rcl_expect("t6_rd10", 10, 1'b1);
        #2;
        rst_n = 0;
        #1;
        check("t6_rst_rcl", 32'(rcl_out), 0);
        check("t6_rst_cnt", 32'(cnt), 0);
        check("t6_rst_err", 32'(err), 0);
        check("t6_rst_rdy", 32'(spk_rdy), 0);
        cyc();
        rst_n = 1;
        cyc();
        do_start();
        check("t6_cnt", 32'(cnt), 0);
        rcl_expect("t6_rd20", 20, 1'b0);
        rcl_expect("t6_rd10b", 10, 1'b0);
        do_start();
        check("t6_cnt2", 32'(cnt), 0);
        rcl_expect("t6_rd25", 25, 1'b0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/in_spike_buf_pp.md
Name: in_spike_buf_pp

Overview:
Next-generation input spike buffer for the neuron core crossbar.
- Ping-pong (double-buffered) recall storage: the next timestep's spikes fill one bank while the crossbar reads the other.
- Spikes arrive as addressed events from the router (valid/ready) or as a bulk vector from the interface. All capture is synchronous to clk_i.
- A learn-history store keeps the last LRN_DEPTH saved timesteps per axon for STDP-style learning reads.

Parameters:
NUM_AXONS, 256, number of axons (buffer width)
AXON_CNT_BIT_WIDTH, 8, axon address width; must satisfy 2**AXON_CNT_BIT_WIDTH >= NUM_AXONS
LRN_DEPTH, 4, timesteps of spike history held per axon for learning (>=1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  timestep boundary pulse (one cycle, synchronous); swaps banks
spk_vld_i  in  1  spike event valid
spk_axon_i  in  AXON_CNT_BIT_WIDTH  target axon of spike event
spk_rdy_o  out  1  event accept ready
bulk_ld_i  in  1  OR spike_in into fill bank this cycle
spike_in  in  NUM_AXONS  bulk spike vector
rdEn_RclInSpike_i  in  1  recall read enable
RclAxonAddr_i  in  AXON_CNT_BIT_WIDTH  recall read address
Rcl_InSpike_o  out  1  recall spike bit (active bank)
saveRclSpikes_i  in  1  push active bank into learn history
rdEn_LrnInSpike_i  in  1  learn read enable
LrnAxonAddr_i  in  AXON_CNT_BIT_WIDTH  learn read address
Lrn_InSpike_o  out  LRN_DEPTH  history of axon; bit0 = most recent saved timestep
rcl_spk_cnt_o  out  AXON_CNT_BIT_WIDTH+1  number of set bits in active bank
err_o  out  1  sticky: event with spk_axon_i >= NUM_AXONS received

Behaviour:
Reset:
- Both banks, learn history, sel, all outputs = 0.
- spk_rdy_o = 0 while rst_n_i is low and 1 from the first clock edge after release.
- Reset mid-timestep discards all captured spikes.

Banks:
- sel selects the active bank; fill bank = !sel.

Event capture:
- Transfer when spk_vld_i & spk_rdy_o: fill[spk_axon_i] <= 1 at that edge.
- Duplicate events are idempotent.
- Out-of-range address: event is accepted and dropped, and err_o is set. err_o clears only on reset.
- spk_rdy_o stays 1 after reset (no backpressure this generation); the port is kept for router compatibility.

Bulk load:
- bulk_ld_i: fill <= fill | spike_in.
- Same-cycle event and bulk load both apply (OR).

start_i (registered swap at the edge):
- sel toggles.
- rcl_spk_cnt_o <= popcount(old fill bank).
- The old active bank becomes the new fill bank and is cleared in the same edge.
- An event or bulk load in the start_i cycle is written into the NEW fill bank (post-swap), so it is never lost or cleared.

Recall read:
- Registered, latency 1: Rcl_InSpike_o <= active[RclAxonAddr_i] using pre-edge sel.
- Output holds when enable is low.
- Address >= NUM_AXONS returns 0.

Learn save:
- saveRclSpikes_i: for every axon, hist <= {hist[LRN_DEPTH-2:0], active[axon]}; the oldest bit is dropped.
- With start_i in the same cycle, the pre-swap active bank is saved.

Learn read:
- Registered, latency 1: Lrn_InSpike_o <= hist[LrnAxonAddr_i].
- Read-before-write with a same-cycle save: returns pre-shift history.
- Out-of-range address returns 0.

Recall read in the start_i cycle returns the pre-swap active bank.

Decomposition:
- Shared package in_spike_pkg: popcount function, AXON_CNT_BIT_WIDTH check, and the learn-history bit-order constant (bit0 = newest).
- Natural sub-module: spike_bank (NUM_AXONS-bit register with set-by-address, OR-load, clear, 1-cycle registered read). Instantiated twice for ping-pong; the learn store stays inline.

Test Plan:
1. Reset, events to axons 3, 7, 7, 200, start_i -> rcl_spk_cnt_o=3; reads of 3/7/200 return 1 one cycle after enable, axon 4 returns 0.
2. Event axon 5 on the same cycle as start_i, then start_i again -> second timestep reads axon 5 = 1 and count=1; no other spikes carried over.
3. bulk_ld_i with spike_in=0x...F0 plus same-cycle event axon 0, start_i -> bits 0,4-7 read 1, count=5.
4. Timestep A = {axon 2}, B = {axon 2, 9}, save after each; learn read axon 2 -> 4'b0011, axon 9 -> 4'b0001; two more empty saves -> axon 2 = 4'b1100.
5. Event with spk_axon_i=300 (NUM_AXONS=256, AXON_CNT_BIT_WIDTH=9) -> err_o=1 sticky, no bank bit set, count unaffected.
6. Assert rst_n_i mid-fill with 10 captured spikes -> outputs 0 immediately; after release and start_i, count=0 and all reads 0.
